multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Moore-style FSM that sequences a multi-cycle MIPS datapath: shared memory, IR, ALU, register file and PC.
- Takes the 6-bit opcode from the instruction register.
- Drives per-state datapath controls, with a memory ready handshake for variable-latency memory.
- Supersedes the single-cycle opcode decoder for the multi-cycle CPU build; supports R-type, lw, sw, beq, addi, j.

Parameters:
OPCODE_W, 6, opcode width
STATE_W, 4, state register width (13 states max)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
opcode  input  OPCODE_W  IR[31:26], valid from DECODE onward
mem_ready  input  1  memory completes current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (beq)
IorD  output  1  0=PC addresses memory, 1=ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  load IR from memory data
MemtoReg  output  1  1=MDR to regfile, 0=ALUOut
RegDst  output  1  1=rd, 0=rt
RegWrite  output  1  regfile write enable
ALUSrcA  output  1  0=PC, 1=regA
ALUSrcB  output  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=funct decode
PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
instr_done  output  1  one-cycle pulse in the final state of each instruction
state  output  STATE_W  current state, debug

Behaviour:
- Single state register, updated on posedge clk. reset=1 at an edge -> state=FETCH.
- While reset=1, PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and instr_done are forced 0, regardless of state.
- All other outputs decode from state. Unlisted outputs are 0 in each state.
- Encodings:
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready=1, then DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
    - Next state by opcode: 100011/101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEX; 000010->JUMP.
    - Any other opcode -> FETCH (NOP, instr_done=1 in DECODE).
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw->MEMRD, sw->MEMWR.
  - MEMRD=3: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next: FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Holds until mem_ready; instr_done=mem_ready. Next: FETCH.
  - EXECUTE=6: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next: FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCWriteCond=1, instr_done=1. Next: FETCH.
  - ADDIEX=9: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB=10: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next: FETCH.
  - JUMP=11: PCSrc=10, PCWrite=1, instr_done=1. Next: FETCH.
  - Unused encodings (12-15, or 13-15 with macro) -> FETCH next cycle; all outputs 0.
- Cycle counts with mem_ready tied high:
  - lw=5; sw=4; R-type=4; addi=4.
  - beq=3; j=3; unsupported opcode=2.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- While a wait state holds, MemRead/MemWrite and IorD stay stable.
- opcode is sampled in DECODE and again in MEMADR. The datapath holds IR stable, so the two samples agree.
- Reset mid-instruction (including during a memory wait): no write strobe in the reset cycle; FETCH on the next cycle.

Optional Feature:
Macro MCTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds state HALT=12 and output port illegal_op (1 bit).
  - In DECODE, an unsupported opcode -> HALT.
  - HALT: all datapath outputs 0, instr_done=0, illegal_op=1. Stays in HALT until reset.
  - illegal_op=0 in every other state and after reset.
- Not defined: no HALT state and no illegal_op port. An unsupported opcode is a 2-cycle NOP as above.

Test Plan:
- reset 2 cycles, mem_ready=1, opcode=100011 -> state 0,1,2,3,4,0. MemRead=1 in 0 and 3; RegWrite=1 and MemtoReg=1 only in 4; instr_done pulses once.
- lw with mem_ready=0 for 2 cycles in FETCH and 3 in MEMRD -> total 10 cycles. IRWrite/PCWrite high only on the FETCH cycle where mem_ready=1; MemRead, IorD=1 held through MEMRD.
- opcode=000000 then 001000 back to back -> R-type: states 0,1,6,7 with ALUOp=10 in 6 and RegDst=1 in 7. addi: states 0,1,9,10 with ALUSrcB=10, RegDst=0.
- opcode=000100 then 000010 -> BRANCH has PCWriteCond=1, ALUOp=01, PCSrc=01. JUMP has PCWrite=1, PCSrc=10. Each takes 3 cycles.
- opcode=101011, assert reset during MEMWR with mem_ready=0 -> MemWrite=0 in the reset cycle; state=0 next cycle; instr_done never pulses.
- opcode=111111: without macro, states 0,1,0 with instr_done=1 in DECODE. With MCTRL_ILLEGAL_TRAP_EN, state 12 and illegal_op=1, held 10 cycles, cleared by reset.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath (R-type, lw, sw, beq, addi, j).
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, unsupported opcode 2 cycles, plus one per memory wait cycle.
// Backpressure: mem_ready=0 holds FETCH, MEMRD or MEMWR with the memory strobes and IorD held stable.
// Optional: define MCTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in HALT and expose illegal_op.
module multicycle_control #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSrc,
  output logic                instr_done,
`ifdef MCTRL_ILLEGAL_TRAP_EN
  output logic                illegal_op,
`endif
  output logic [STATE_W-1:0]  state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,HALT   = 4'd12
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  // Raw per-state values of the outputs that reset must suppress.
  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic instr_done_raw;

  // State register: reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state output decode; anything not set here stays 0.
  always_comb begin
    state_d           = state_q;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    reg_write_raw     = 1'b0;
    instr_done_raw    = 1'b0;
    IorD              = 1'b0;
    MemRead           = 1'b0;
    MemtoReg          = 1'b0;
    RegDst            = 1'b0;
    ALUSrcA           = 1'b0;
    ALUSrcB           = 2'b00;
    ALUOp             = 2'b00;
    PCSrc             = 2'b00;

    case (state_q)
      FETCH: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // Speculative branch target computation while the opcode resolves.
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            state_d        = FETCH;
            instr_done_raw = 1'b1;
`endif
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is held, so this second look at opcode matches DECODE's.
        if (opcode == OP_LW) begin
          state_d = MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = MEMWR;
        end else begin
          state_d = FETCH;
        end
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        MemtoReg       = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        mem_write_raw  = 1'b1;
        IorD           = 1'b1;
        instr_done_raw = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        RegDst         = 1'b1;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = 2'b01;
        PCSrc             = 2'b01;
        pc_write_cond_raw = 1'b1;
        instr_done_raw    = 1'b1;
        state_d           = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
      JUMP: begin
        PCSrc          = 2'b10;
        pc_write_raw   = 1'b1;
        instr_done_raw = 1'b1;
        state_d        = FETCH;
      end
`ifdef MCTRL_ILLEGAL_TRAP_EN
      HALT: begin
        // Parked until reset; the datapath stays idle.
        state_d = HALT;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Reset blanks every state-changing strobe, even mid memory wait.
  assign PCWrite     = pc_write_raw      & ~reset;
  assign PCWriteCond = pc_write_cond_raw & ~reset;
  assign IRWrite     = ir_write_raw      & ~reset;
  assign MemWrite    = mem_write_raw     & ~reset;
  assign RegWrite    = reg_write_raw     & ~reset;
  assign instr_done  = instr_done_raw    & ~reset;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign illegal_op  = (state_q == HALT) & ~reset;
`endif
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle scoreboard of state and controls.
// Latency: checks every cycle of each instruction sequence, including memory wait cycles.
// Backpressure: mem_ready is driven low in FETCH/MEMRD/MEMWR to exercise wait states.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      ctrl;
    logic       illegal;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] state;
  logic       illegal_op;

  int checks;
  int failures;
  exp_t sb[$];

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSrc       (PCSrc),
    .instr_done  (instr_done),
`ifdef MCTRL_ILLEGAL_TRAP_EN
    .illegal_op  (illegal_op),
`endif
    .state       (state)
  );

`ifndef MCTRL_ILLEGAL_TRAP_EN
  assign illegal_op = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected controls straight from the state table in the design description.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                     input logic mr, input logic rst);
    ctrl_t c;
    logic  supported;
    supported = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    c = '0;
    case (st)
      4'd0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      4'd1: begin
        c.alu_src_b = 2'b11;
`ifndef MCTRL_ILLEGAL_TRAP_EN
        c.instr_done = !supported;
`endif
      end
      4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1; c.iord = 1; end
      4'd4:  begin c.mem_to_reg = 1; c.reg_write = 1; c.instr_done = 1; end
      4'd5:  begin c.mem_write = 1; c.iord = 1; c.instr_done = mr; end
      4'd6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_dst = 1; c.reg_write = 1; c.instr_done = 1; end
      4'd8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                   c.pc_write_cond = 1; c.instr_done = 1; end
      4'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      4'd10: begin c.reg_write = 1; c.instr_done = 1; end
      4'd11: begin c.pc_src = 2'b10; c.pc_write = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    if (rst) begin
      c.pc_write = 0; c.pc_write_cond = 0; c.ir_write = 0;
      c.mem_write = 0; c.reg_write = 0; c.instr_done = 0;
    end
    return c;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] es);
    exp_t e;
    exp_t got;
    ctrl_t obs;
    reset     = r;
    opcode    = op;
    mem_ready = mr;
    e.st      = es;
    e.ctrl    = exp_ctrl(es, op, mr, r);
    e.illegal = (es == 4'd12) && !r;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done};
    checks++;
    if (state !== got.st) begin
      failures++;
      $display("FAIL state t=%0t got=%0d want=%0d", $time, state, got.st);
    end
    checks++;
    if (obs !== got.ctrl) begin
      failures++;
      $display("FAIL ctrl st=%0d t=%0t got=%h want=%h", got.st, $time, obs, got.ctrl);
    end
`ifdef MCTRL_ILLEGAL_TRAP_EN
    checks++;
    if (illegal_op !== got.illegal) begin
      failures++;
      $display("FAIL illegal_op t=%0t got=%b want=%b", $time, illegal_op, got.illegal);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 6'b100011, 1'b1, 4'd0);
    cyc(1'b1, 6'b100011, 1'b1, 4'd0);
  endtask

  task automatic test_lw();
    cyc(0, 6'b100011, 1, 4'd0);
    cyc(0, 6'b100011, 1, 4'd1);
    cyc(0, 6'b100011, 1, 4'd2);
    cyc(0, 6'b100011, 1, 4'd3);
    cyc(0, 6'b100011, 1, 4'd4);
  endtask

  task automatic test_lw_wait();
    cyc(0, 6'b100011, 0, 4'd0);
    cyc(0, 6'b100011, 0, 4'd0);
    cyc(0, 6'b100011, 1, 4'd0);
    cyc(0, 6'b100011, 1, 4'd1);
    cyc(0, 6'b100011, 1, 4'd2);
    for (int i = 0; i < 3; i++) cyc(0, 6'b100011, 0, 4'd3);
    cyc(0, 6'b100011, 1, 4'd3);
    cyc(0, 6'b100011, 1, 4'd4);
  endtask

  task automatic test_back_to_back();
    cyc(0, 6'b000000, 1, 4'd0);
    cyc(0, 6'b000000, 1, 4'd1);
    cyc(0, 6'b000000, 1, 4'd6);
    cyc(0, 6'b000000, 1, 4'd7);
    cyc(0, 6'b001000, 1, 4'd0);
    cyc(0, 6'b001000, 1, 4'd1);
    cyc(0, 6'b001000, 1, 4'd9);
    cyc(0, 6'b001000, 1, 4'd10);
  endtask

  task automatic test_branch_jump();
    cyc(0, 6'b000100, 1, 4'd0);
    cyc(0, 6'b000100, 1, 4'd1);
    cyc(0, 6'b000100, 1, 4'd8);
    cyc(0, 6'b000010, 1, 4'd0);
    cyc(0, 6'b000010, 1, 4'd1);
    cyc(0, 6'b000010, 1, 4'd11);
  endtask

  task automatic test_sw();
    cyc(0, 6'b101011, 1, 4'd0);
    cyc(0, 6'b101011, 1, 4'd1);
    cyc(0, 6'b101011, 1, 4'd2);
    cyc(0, 6'b101011, 0, 4'd5);
    cyc(0, 6'b101011, 1, 4'd5);
  endtask

  task automatic test_reset_in_memwr();
    cyc(0, 6'b101011, 1, 4'd0);
    cyc(0, 6'b101011, 1, 4'd1);
    cyc(0, 6'b101011, 1, 4'd2);
    cyc(0, 6'b101011, 0, 4'd5);
    cyc(1, 6'b101011, 0, 4'd5);
    cyc(0, 6'b101011, 1, 4'd0);
    cyc(0, 6'b101011, 1, 4'd1);
  endtask

  task automatic test_illegal();
    cyc(0, 6'b111111, 1, 4'd0);
    cyc(0, 6'b111111, 1, 4'd1);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) cyc(0, 6'b111111, 1, 4'd12);
    cyc(1, 6'b111111, 1, 4'd12);
    cyc(0, 6'b000010, 1, 4'd0);
`else
    cyc(0, 6'b111111, 1, 4'd0);
    cyc(0, 6'b111111, 1, 4'd1);
    cyc(0, 6'b111111, 1, 4'd0);
`endif
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    opcode    = 6'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_lw();
    test_lw_wait();
    test_back_to_back();
    test_branch_jump();
    test_sw();
    test_reset_in_memwr();
    // Finish the interrupted sw's successor cleanly before the illegal opcode.
    cyc(1, 6'b000000, 1, 4'd2);
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
